// File: rtl/led_matrix_column_scanner_pkg.sv
// Shared definitions for the 5x7 LED matrix column scanner: geometry, FSM state
// encoding and small helpers for picking a column out of a packed frame.
package led_matrix_column_scanner_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int FRAME_W  = NUM_COLS * NUM_ROWS;
  localparam int COL_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [COL_W-1:0] col);
    col_onehot = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col == COL_W'(c)) col_onehot[c] = 1'b1;
    end
  endfunction

  // Column c occupies frame bits [c*NUM_ROWS +: NUM_ROWS], row r at bit c*NUM_ROWS+r.
  function automatic logic [NUM_ROWS-1:0] col_rows(input logic [FRAME_W-1:0] frame,
                                                   input logic [COL_W-1:0]   col);
    col_rows = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col == COL_W'(c)) col_rows = frame[c*NUM_ROWS +: NUM_ROWS];
    end
  endfunction

endpackage

// File: rtl/led_matrix_column_scanner_if.sv
// Frame transfer channel: a whole packed 5x7 frame moves on frame_valid & frame_ready.
interface led_matrix_column_scanner_if;
  import led_matrix_column_scanner_pkg::*;

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (output frame_data, output frame_valid, input  frame_ready);
  modport slave  (input  frame_data, input  frame_valid, output frame_ready);

endinterface

// File: rtl/led_matrix_column_scanner_slot_timer.sv
// Per-column slot counter: counts 0..SLOT_CYCLES-1 and flags the end of the blanking
// window and the end of the slot.
module led_matrix_slot_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign slot_done  = (cnt_q == SLOT_LAST);
  assign blank_done = HAS_BLANK && (cnt_q == BLANK_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = slot_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_matrix_column_scanner.sv
// Double-buffered 5x7 LED matrix scanner: takes whole frames over a valid/ready channel and
// multiplexes the displayed frame one column per slot, blanking at the start of each slot.
module led_matrix_column_scanner
  import led_matrix_column_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit COL_ACT_LOW  = 1'b1,
  parameter bit ROW_ACT_LOW  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  led_matrix_column_scanner_if.slave   frm,
  output logic [NUM_COLS-1:0]          column_select,
  output logic [NUM_ROWS-1:0]          row_drive,
  output logic                         frame_start
);

  localparam bit                 HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [NUM_COLS-1:0] COL_OFF  = {NUM_COLS{COL_ACT_LOW}};
  localparam logic [NUM_ROWS-1:0] ROW_OFF  = {NUM_ROWS{ROW_ACT_LOW}};

  function automatic logic [NUM_COLS-1:0] drive_cols(input logic [NUM_COLS-1:0] on);
    drive_cols = on ^ COL_OFF;
  endfunction

  function automatic logic [NUM_ROWS-1:0] drive_rows(input logic [NUM_ROWS-1:0] lit);
    drive_rows = lit ^ ROW_OFF;
  endfunction

  scan_state_e         state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [FRAME_W-1:0]  display_q, display_d;
  logic [FRAME_W-1:0]  pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
  logic [NUM_ROWS-1:0] row_q, row_d;
  logic                frame_start_q, frame_start_d;
  logic                timer_clr, timer_en, blank_done, slot_done, boundary;

  led_matrix_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .clr        (timer_clr),
    .en         (timer_en),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // Ready can only be high while the pending buffer is empty, and a swap needs it full,
  // so acceptance and the boundary swap never touch the pending buffer in the same cycle.
  assign frm.frame_ready = ~pending_full_q & ~reset;

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    timer_clr      = 1'b0;
    timer_en       = 1'b0;
    boundary       = 1'b0;

    if (frm.frame_valid && frm.frame_ready) begin
      pending_d      = frm.frame_data;
      pending_full_d = 1'b1;
    end

    if (!enable) begin
      state_d   = S_IDLE;
      col_d     = '0;
      timer_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = HAS_BLANK ? S_BLANK : S_SHOW;
          col_d     = '0;
          timer_clr = 1'b1;
          boundary  = 1'b1;
        end
        S_BLANK: begin
          timer_en = 1'b1;
          if (blank_done) state_d = S_SHOW;
        end
        S_SHOW: begin
          timer_en = 1'b1;
          if (slot_done) begin
            state_d = HAS_BLANK ? S_BLANK : S_SHOW;
            if (col_q == LAST_COL) begin
              col_d    = '0;
              boundary = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          col_d     = '0;
          timer_clr = 1'b1;
        end
      endcase
    end

    if (boundary && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end

    // Outputs follow the next state so they line up with the state they describe.
    col_sel_d     = COL_OFF;
    row_d         = ROW_OFF;
    frame_start_d = 1'b0;
    if (state_d == S_SHOW) begin
      col_sel_d     = drive_cols(col_onehot(col_d));
      row_d         = drive_rows(col_rows(display_d, col_d));
      frame_start_d = (col_d == '0) && !((state_q == S_SHOW) && (col_q == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      display_q      <= '0;
      pending_full_q <= 1'b0;
      col_sel_q      <= COL_OFF;
      row_q          <= ROW_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      display_q      <= display_d;
      pending_full_q <= pending_full_d;
      col_sel_q      <= col_sel_d;
      row_q          <= row_d;
      frame_start_q  <= frame_start_d;
    end
  end

  always_ff @(posedge clk) begin
    pending_q <= pending_d;
  end

  assign column_select = col_sel_q;
  assign row_drive     = row_q;
  assign frame_start   = frame_start_q;

endmodule
